shake_arbiter: RTL and testbench
================================

SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the SHAKE engine.
REQ-002 Parameter DW, default 64: engine data-word width.
REQ-003 Parameter TIMEOUT_CYC, default 4096: watchdog limit in cycles, used only under REQ-027.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  NREQ  per-requester engine request, level.
REQ-007 req_cmd  input  NREQ*8  per-requester command; slice i belongs to requester i.
REQ-008 req_din  input  NREQ*DW  per-requester absorb data; slice i belongs to requester i.
REQ-009 gnt  output  NREQ  one-hot ownership grant.
REQ-010 done  output  NREQ  one-cycle completion pulse to the owner.
REQ-011 dout_valid  output  NREQ  engine output-valid, routed to the owner only.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 err  output  1  one-cycle timeout pulse, asserted together with done.
REQ-014 eng_start  output  1  one-cycle engine start pulse.
REQ-015 eng_cmd  output  8  latched command of the owner.
REQ-016 eng_din  output  DW  req_din slice of the owner; zero when there is no owner.
REQ-017 eng_done  input  1  engine completion pulse.
REQ-018 eng_dout_valid  input  1  engine squeeze-output valid.

Function
REQ-019 FSM states: IDLE, START, RUN, RELEASE; IDLE->START when any req bit is 1 in IDLE; START->RUN unconditionally; RUN->RELEASE on eng_done; RELEASE->IDLE unconditionally.
REQ-020 Round-robin arbitration in IDLE:
- Search starts at index ptr+1 and wraps modulo NREQ.
- The first set req bit wins.
- The winner index and its req_cmd slice are latched into owner and cmd_reg on the IDLE->START edge.
REQ-021 In START, gnt[owner]=1 and eng_start=1 for exactly one cycle; eng_cmd=cmd_reg from START through RELEASE.
REQ-022 In START and RUN:
- gnt[owner]=1 and all other gnt bits are 0.
- eng_din equals the owner's req_din slice.
- dout_valid[owner] equals eng_dout_valid combinationally; all other dout_valid bits are 0.
REQ-023 eng_done is ignored in IDLE, START and RELEASE.
REQ-024 In RELEASE:
- done[owner]=1 for one cycle; gnt is all zero.
- ptr is loaded with owner.
- Request-to-start latency is 1 cycle; minimum tenure from START to RELEASE is 3 cycles when eng_done arrives on the first RUN cycle.
REQ-025 Ownership persists until eng_done even if req[owner] drops mid-tenure.
- A req bit still high in IDLE after done counts as a new request.
- Grants are never pre-empted.
REQ-026 eng_dout_valid outside START/RUN produces no dout_valid.

Configuration
REQ-027 With macro SHAKE_ARB_TIMEOUT_EN defined, a 16-bit counter runs while in RUN:
- The counter clears on entry to RUN.
- If it reaches TIMEOUT_CYC-1 without eng_done, the FSM moves to RELEASE and err=1 in that RELEASE cycle, alongside done[owner].
REQ-028 With SHAKE_ARB_TIMEOUT_EN undefined:
- No counter is implemented and err is tied to 0.
- RUN waits on eng_done indefinitely.

Reset
REQ-029 With rst=1 at a clock edge, on the next cycle:
- state=IDLE, owner=0, cmd_reg=0, ptr=NREQ-1, counter=0.
- gnt, done, dout_valid, eng_start and err are 0; busy=0; eng_cmd=0.
- A requester 0 request therefore wins first after reset.
REQ-030 rst asserted mid-tenure aborts the tenure without any done pulse; the engine is reset by the same rst.

Verification
REQ-031 After reset, req=3'b111 with req_cmd slices 0x11, 0x22, 0x33; each tenure's eng_done arrives 5 cycles after eng_start, and each requester drops its req on its done -> grants go to 0, 1, 2 in order, eng_cmd is 0x11, 0x22, 0x33, each tenure lasts 7 cycles, and there is exactly one done per requester.
REQ-032 req=3'b010 held continuously with eng_done 2 cycles after eng_start each time -> requester 1 is re-granted every 5 cycles, with 1 IDLE cycle between tenures.
REQ-033 Owner 2 in RUN, eng_dout_valid pulsed 4 times -> dout_valid=3'b100 on exactly those 4 cycles.
REQ-034 Owner 0 drops req 2 cycles into RUN while req[1] is high -> gnt stays 3'b001 until eng_done, then done[0] pulses, then requester 1 is granted.
REQ-035 rst asserted during RUN with owner 1 -> next cycle gnt=0 and busy=0, with no done pulse; then req=3'b110 -> requester 1 is granted.
REQ-036 SHAKE_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, eng_done never asserted -> RELEASE entered 16 cycles after RUN entry, with err=1 and done[owner]=1 in the same cycle; undefined -> busy stays 1 and err stays 0.

Source files
------------

// File: rtl/shake_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shake_arbiter
//  Description : Round-robin arbiter that shares one SHAKE engine between
//                NREQ requesters. A winner owns the engine from START until
//                the engine reports completion and is never pre-empted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              rising-edge clock
//    rst              synchronous active-high reset
//    req_i            per-requester request level            [NREQ]
//    req_cmd_i        per-requester command, 8 bits each     [NREQ*8]
//    req_din_i        per-requester absorb data, DW each     [NREQ*DW]
//    gnt_o            one-hot ownership grant (START/RUN)    [NREQ]
//    done_o           one-cycle completion pulse to owner    [NREQ]
//    dout_valid_o     engine output-valid routed to owner    [NREQ]
//    busy_o           high whenever the FSM is not IDLE
//    err_o            one-cycle timeout pulse (with done_o)
//    eng_start_o      one-cycle engine start pulse
//    eng_cmd_o        latched command of the owner           [8]
//    eng_din_o        owner's absorb data, zero if no owner  [DW]
//    eng_done_i       engine completion pulse
//    eng_dout_valid_i engine squeeze-output valid
//  Configuration
//    SHAKE_ARB_TIMEOUT_EN  when defined, a 16-bit watchdog forces RELEASE
//                          after TIMEOUT_CYC cycles in RUN and raises err_o.
//                          When undefined, RUN waits on eng_done_i forever
//                          and err_o is tied low.
// ============================================================================
module shake_arbiter #(
  parameter int NREQ        = 3,
  parameter int DW          = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*8-1:0] req_cmd_i,
  input  logic [NREQ*DW-1:0] req_din_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [NREQ-1:0]   dout_valid_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              eng_start_o,
  output logic [7:0]        eng_cmd_o,
  output logic [DW-1:0]     eng_din_o,
  input  logic              eng_done_i,
  input  logic              eng_dout_valid_i
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [7:0]    cmd_q, cmd_d;

  logic [7:0]    w_cmd [NREQ];
  logic [DW-1:0] w_din [NREQ];
  logic [OW-1:0] w_pick;
  logic          w_tmo_hit;

  // Unpack the flat per-requester buses so the owner can index them directly.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_cmd[gi] = req_cmd_i[gi*8 +: 8];
      assign w_din[gi] = req_din_i[gi*DW +: DW];
    end
  endgenerate

  // Round-robin pick: scan from p+1 upward, wrapping at NREQ, first set bit
  // wins. The result is only consumed when at least one request is set.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [OW-1:0]   p);
    logic [OW-1:0] idx;
    logic          found;
    rr_pick = '0;
    found   = 1'b0;
    idx     = p;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == OW'(NREQ - 1)) ? '0 : idx + OW'(1);
      if (!found && r[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

  assign w_pick = rr_pick(req_i, ptr_q);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      cmd_q   <= '0;
      ptr_q   <= OW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      ptr_q   <= ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d = S_START;
          owner_d = w_pick;
          cmd_d   = w_cmd[w_pick];
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // Completion is only honoured here; elsewhere eng_done_i is ignored.
        if (eng_done_i || w_tmo_hit) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        ptr_d   = owner_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_o        = '0;
    done_o       = '0;
    dout_valid_o = '0;
    eng_start_o  = 1'b0;
    eng_cmd_o    = '0;
    eng_din_o    = '0;
    busy_o       = (state_q != S_IDLE);
    case (state_q)
      S_START: begin
        eng_start_o           = 1'b1;
        gnt_o[owner_q]        = 1'b1;
        eng_cmd_o             = cmd_q;
        eng_din_o             = w_din[owner_q];
        dout_valid_o[owner_q] = eng_dout_valid_i;
      end
      S_RUN: begin
        gnt_o[owner_q]        = 1'b1;
        eng_cmd_o             = cmd_q;
        eng_din_o             = w_din[owner_q];
        dout_valid_o[owner_q] = eng_dout_valid_i;
      end
      S_RELEASE: begin
        done_o[owner_q] = 1'b1;
        eng_cmd_o       = cmd_q;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Optional RUN watchdog
  // --------------------------------------------------------------------------
`ifdef SHAKE_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q;

  // Counter value k means the FSM is in its (k+1)-th RUN cycle.
  assign w_tmo_hit = (state_q == S_RUN) && !eng_done_i &&
                     (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_START) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_RUN) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  // tmo_q remembers that the RUN->RELEASE step was caused by the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= w_tmo_hit;
    end
  end

  assign err_o = (state_q == S_RELEASE) && tmo_q;
`else
  logic w_unused_timeout;

  assign w_tmo_hit        = 1'b0;
  assign err_o            = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_shake_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shake_arbiter
//  Description : Directed self-checking bench for shake_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shake_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 64;
`ifdef SHAKE_ARB_TIMEOUT_EN
  localparam int TMO  = 16;
`else
  localparam int TMO  = 4096;
`endif

  localparam logic [DW-1:0] D0 = 64'hA0A0_0000_1111_0001;
  localparam logic [DW-1:0] D1 = 64'hB1B1_0000_2222_0002;
  localparam logic [DW-1:0] D2 = 64'hC2C2_0000_3333_0003;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_cmd;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   dout_valid;
  logic              busy;
  logic              err;
  logic              eng_start;
  logic [7:0]        eng_cmd;
  logic [DW-1:0]     eng_din;
  logic              eng_done;
  logic              eng_dout_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shake_arbiter #(
    .NREQ        (NREQ),
    .DW          (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_i            (req),
    .req_cmd_i        (req_cmd),
    .req_din_i        (req_din),
    .gnt_o            (gnt),
    .done_o           (done),
    .dout_valid_o     (dout_valid),
    .busy_o           (busy),
    .err_o            (err),
    .eng_start_o      (eng_start),
    .eng_cmd_o        (eng_cmd),
    .eng_din_o        (eng_din),
    .eng_done_i       (eng_done),
    .eng_dout_valid_i (eng_dout_valid)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; eng_done = 1'b0; eng_dout_valid = 1'b1;
    step; step;
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt got %b exp 000", gnt); end
    n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL rst_done got %b exp 000", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_vec++; if (eng_start !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_start_err got %b%b exp 00", eng_start, err); end
    n_vec++; if (eng_cmd !== 8'h00) begin n_err++; $display("FAIL rst_cmd got %h exp 00", eng_cmd); end
    n_vec++; if (dout_valid !== 3'b000) begin n_err++; $display("FAIL rst_dv got %b exp 000", dout_valid); end
    n_vec++; if (eng_din !== '0) begin n_err++; $display("FAIL rst_din got %h exp 0", eng_din); end
    rst = 1'b0; eng_dout_valid = 1'b0;
    step;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  // Three requesters, engine done 5 cycles after start, each drops on done.
  task automatic test_round_robin;
    logic [7:0]    exp_cmd;
    logic [DW-1:0] exp_din;
    req = 3'b111;
    for (int o = 0; o < 3; o++) begin
      exp_cmd = 8'(8'h11 * (o + 1));
      exp_din = (o == 0) ? D0 : (o == 1) ? D1 : D2;
      step; // START
      n_vec++; if (gnt !== (3'b001 << o) || eng_start !== 1'b1) begin n_err++; $display("FAIL rr_start[%0d] gnt %b start %b exp %b 1", o, gnt, eng_start, 3'b001 << o); end
      n_vec++; if (eng_cmd !== exp_cmd) begin n_err++; $display("FAIL rr_cmd[%0d] got %h exp %h", o, eng_cmd, exp_cmd); end
      n_vec++; if (eng_din !== exp_din) begin n_err++; $display("FAIL rr_din[%0d] got %h exp %h", o, eng_din, exp_din); end
      repeat (5) step; // last RUN cycle
      n_vec++; if (gnt !== (3'b001 << o) || eng_start !== 1'b0 || done !== 3'b000) begin n_err++; $display("FAIL rr_run[%0d] gnt %b start %b done %b", o, gnt, eng_start, done); end
      eng_done = 1'b1;
      step; // RELEASE, seventh tenure cycle
      eng_done = 1'b0;
      n_vec++; if (done !== (3'b001 << o) || gnt !== 3'b000 || err !== 1'b0) begin n_err++; $display("FAIL rr_rel[%0d] done %b gnt %b err %b exp %b 000 0", o, done, gnt, err, 3'b001 << o); end
      n_vec++; if (eng_cmd !== exp_cmd) begin n_err++; $display("FAIL rr_relcmd[%0d] got %h exp %h", o, eng_cmd, exp_cmd); end
      req[o] = 1'b0;
      step; // IDLE
      n_vec++; if (done !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL rr_idle[%0d] done %b busy %b exp 000 0", o, done, busy); end
    end
  endtask

  // Requester 1 held high, engine done 2 cycles after start: 5-cycle period.
  task automatic test_back_to_back;
    req = 3'b010;
    step; // START
    for (int n = 0; n < 3; n++) begin
      n_vec++; if (gnt !== 3'b010 || eng_start !== 1'b1) begin n_err++; $display("FAIL b2b_start[%0d] gnt %b start %b exp 010 1", n, gnt, eng_start); end
      step; step;
      eng_done = 1'b1;
      step; // RELEASE
      eng_done = 1'b0;
      n_vec++; if (done !== 3'b010 || gnt !== 3'b000) begin n_err++; $display("FAIL b2b_rel[%0d] done %b gnt %b exp 010 000", n, done, gnt); end
      if (n == 2) req = 3'b000;
      step; // IDLE
      n_vec++; if (busy !== 1'b0 || gnt !== 3'b000) begin n_err++; $display("FAIL b2b_idle[%0d] busy %b gnt %b exp 0 000", n, busy, gnt); end
      if (n < 2) step;
    end
  endtask

  // Owner 2 in RUN, eng_dout_valid pulsed on 4 of 8 cycles.
  task automatic test_dout_valid;
    logic [7:0] pat;
    int         ones;
    pat  = 8'b0110_1001;
    ones = 0;
    eng_dout_valid = 1'b1; req = 3'b100;
    #1;
    n_vec++; if (dout_valid !== 3'b000) begin n_err++; $display("FAIL dv_idle got %b exp 000", dout_valid); end
    eng_dout_valid = 1'b0;
    step; // START, owner 2
    step; // RUN
    n_vec++; if (eng_din !== D2) begin n_err++; $display("FAIL dv_din got %h exp %h", eng_din, D2); end
    req_din[2*DW +: DW] = ~D2;
    #1;
    n_vec++; if (eng_din !== ~D2) begin n_err++; $display("FAIL dv_din_follow got %h exp %h", eng_din, ~D2); end
    req_din[2*DW +: DW] = D2;
    for (int i = 0; i < 8; i++) begin
      eng_dout_valid = pat[i];
      #1;
      n_vec++; if (dout_valid !== (pat[i] ? 3'b100 : 3'b000)) begin n_err++; $display("FAIL dv_run[%0d] got %b exp %b", i, dout_valid, pat[i] ? 3'b100 : 3'b000); end
      if (dout_valid[2]) ones++;
      step;
    end
    n_vec++; if (ones != 4) begin n_err++; $display("FAIL dv_count got %0d exp 4", ones); end
    eng_dout_valid = 1'b0; eng_done = 1'b1;
    step; // RELEASE
    eng_done = 1'b0; eng_dout_valid = 1'b1;
    #1;
    n_vec++; if (dout_valid !== 3'b000 || done !== 3'b100) begin n_err++; $display("FAIL dv_rel dv %b done %b exp 000 100", dout_valid, done); end
    eng_dout_valid = 1'b0; req = 3'b000;
    step; // IDLE
  endtask

  // Owner 0 drops its request mid-tenure while requester 1 waits.
  task automatic test_ownership_hold;
    req = 3'b011;
    step; // START (ptr=2 -> requester 0)
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL hold_start got %b exp 001", gnt); end
    step; step; step; // RUN + 2
    req = 3'b010;
    #1;
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL hold_drop got %b exp 001", gnt); end
    step;
    n_vec++; if (gnt !== 3'b001 || done !== 3'b000) begin n_err++; $display("FAIL hold_keep gnt %b done %b exp 001 000", gnt, done); end
    eng_done = 1'b1;
    step; // RELEASE
    eng_done = 1'b0;
    n_vec++; if (done !== 3'b001) begin n_err++; $display("FAIL hold_done got %b exp 001", done); end
    step; // IDLE
    step; // START requester 1
    n_vec++; if (gnt !== 3'b010 || eng_cmd !== 8'h22) begin n_err++; $display("FAIL hold_next gnt %b cmd %h exp 010 22", gnt, eng_cmd); end
  endtask

  // Reset during RUN with owner 1 aborts the tenure without done.
  task automatic test_reset_mid;
    step; step; // RUN
    n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rmid_pre got %b exp 010", gnt); end
    rst = 1'b1; req = 3'b000;
    step;
    rst = 1'b0;
    n_vec++; if (gnt !== 3'b000 || busy !== 1'b0 || done !== 3'b000) begin n_err++; $display("FAIL rmid_abort gnt %b busy %b done %b exp 000 0 000", gnt, busy, done); end
    step;
    n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL rmid_nodone got %b exp 000", done); end
    req = 3'b110;
    step; // START
    n_vec++; if (gnt !== 3'b010 || eng_start !== 1'b1) begin n_err++; $display("FAIL rmid_regrant gnt %b start %b exp 010 1", gnt, eng_start); end
    step;
    eng_done = 1'b1;
    step; // RELEASE
    eng_done = 1'b0;
    n_vec++; if (done !== 3'b010) begin n_err++; $display("FAIL rmid_done got %b exp 010", done); end
    req = 3'b000;
    step; // IDLE
  endtask

  // Engine never completes.
  task automatic test_timeout;
    logic bad;
    bad = 1'b0;
    req = 3'b001;
    step; // START (ptr=1 -> requester 0 via wrap)
    req = 3'b000;
    step; // first RUN cycle
`ifdef SHAKE_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      step;
      if (done !== 3'b000 || busy !== 1'b1 || err !== 1'b0) bad = 1'b1;
    end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL tmo_early got early release/err exp none"); end
    step; // 16 cycles after RUN entry
    n_vec++; if (done !== 3'b001 || err !== 1'b1) begin n_err++; $display("FAIL tmo_rel done %b err %b exp 001 1", done, err); end
    step;
    n_vec++; if (err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL tmo_after err %b busy %b exp 0 0", err, busy); end
`else
    for (int k = 0; k < 40; k++) begin
      step;
      if (busy !== 1'b1 || err !== 1'b0 || done !== 3'b000) bad = 1'b1;
    end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL tmo_hold got release or err exp busy held"); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL tmo_recover busy %b err %b exp 0 0", busy, err); end
`endif
  endtask

  initial begin
    rst = 1'b1; req = '0; eng_done = 1'b0; eng_dout_valid = 1'b0;
    req_cmd = {8'h33, 8'h22, 8'h11};
    req_din = {D2, D1, D0};
    test_reset;
    test_round_robin;
    test_back_to_back;
    test_dout_valid;
    test_ownership_hold;
    test_reset_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
